// File: rtl/bsg_axil_arb_pkg.sv
// Shared definitions for the AXI4-Lite request arbiter.
//   arb_state_e      : transaction sequencer states
//   axi_resp_*_c     : AXI response encodings
//   axil_prot_c      : constant protection attribute driven on AW/AR
//   axi_resp_is_err  : a response is an error when resp[1] is set (SLVERR/DECERR)
package bsg_axil_arb_pkg;

   typedef enum logic [2:0] {
      e_idle,
      e_wr,
      e_wr_resp,
      e_rd,
      e_rd_resp,
      e_resp
   } arb_state_e;

   localparam logic [1:0] axi_resp_okay_c   = 2'b00;
   localparam logic [1:0] axi_resp_exokay_c = 2'b01;
   localparam logic [1:0] axi_resp_slverr_c = 2'b10;
   localparam logic [1:0] axi_resp_decerr_c = 2'b11;

   localparam logic [2:0] axil_prot_c = 3'b000;

   function automatic logic axi_resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/bsg_rr_grant.sv
// Round-robin priority encoder with its own pointer register.
//   clk_i, reset_i : clock, asynchronous active-high reset (pointer -> 0)
//   en_i           : grant enable; the pointer only advances on an enabled grant
//   req_i          : request vector
//   grant_o        : one-hot grant (first set bit at or after the pointer)
//   grant_id_o     : index of the granted requester
//   grant_v_o      : any request present
module bsg_rr_grant #(
   parameter int num_req_p = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         en_i,
   input  logic [num_req_p-1:0]         req_i,
   output logic [num_req_p-1:0]         grant_o,
   output logic [$clog2(num_req_p)-1:0] grant_id_o,
   output logic                         grant_v_o
);

   localparam int id_width_lp = $clog2(num_req_p);

   logic [id_width_lp-1:0] ptr_r;

   // NOTE: every output of this block gets a default before the loop, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      int idx;
      idx        = 0;
      grant_o    = '0;
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      // Scan from the pointer upward, wrapping past the last requester.
      for (int k = 0; k < num_req_p; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!grant_v_o && req_i[idx]) begin
            grant_v_o    = 1'b1;
            grant_o[idx] = 1'b1;
            grant_id_o   = id_width_lp'(idx);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same clock edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_r <= '0;
      end else if (en_i && grant_v_o) begin
         ptr_r <= (grant_id_o == id_width_lp'(num_req_p - 1)) ? '0 : grant_id_o + 1'b1;
      end
   end

endmodule

// File: rtl/bsg_axil_req_arbiter.sv
// Shares one AXI4-Lite master port among num_req_p single-beat requesters.
// One transaction is in flight at a time; owners are chosen round-robin.
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   req_v/w/addr/data/mask  : packed per-requester commands (valid/yumi)
//   req_yumi_o              : one-hot, same-cycle command accept
//   resp_v_o/data_o/err_o   : response to the owner (valid/ready)
//   resp_ready_i            : per-requester response ready
//   m_axil_aw/w/b/ar/r      : AXI4-Lite master channels
module bsg_axil_req_arbiter
   import bsg_axil_arb_pkg::*;
#(
   parameter int num_req_p    = 2,
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,

   input  logic [num_req_p-1:0]                  req_v_i,
   input  logic [num_req_p-1:0]                  req_w_i,
   input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
   input  logic [num_req_p*data_width_p-1:0]     req_data_i,
   input  logic [num_req_p*(data_width_p/8)-1:0] req_mask_i,
   output logic [num_req_p-1:0]                  req_yumi_o,

   output logic [num_req_p-1:0]                  resp_v_o,
   output logic [data_width_p-1:0]               resp_data_o,
   output logic                                  resp_err_o,
   input  logic [num_req_p-1:0]                  resp_ready_i,

   output logic [addr_width_p-1:0]               m_axil_awaddr_o,
   output logic [2:0]                            m_axil_awprot_o,
   output logic                                  m_axil_awvalid_o,
   input  logic                                  m_axil_awready_i,

   output logic [data_width_p-1:0]               m_axil_wdata_o,
   output logic [data_width_p/8-1:0]             m_axil_wstrb_o,
   output logic                                  m_axil_wvalid_o,
   input  logic                                  m_axil_wready_i,

   input  logic [1:0]                            m_axil_bresp_i,
   input  logic                                  m_axil_bvalid_i,
   output logic                                  m_axil_bready_o,

   output logic [addr_width_p-1:0]               m_axil_araddr_o,
   output logic [2:0]                            m_axil_arprot_o,
   output logic                                  m_axil_arvalid_o,
   input  logic                                  m_axil_arready_i,

   input  logic [data_width_p-1:0]               m_axil_rdata_i,
   input  logic [1:0]                            m_axil_rresp_i,
   input  logic                                  m_axil_rvalid_i,
   output logic                                  m_axil_rready_o
);

   localparam int id_width_lp   = $clog2(num_req_p);
   localparam int strb_width_lp = data_width_p / 8;

   arb_state_e               state_r;
   logic [id_width_lp-1:0]   owner_r;
   logic [addr_width_p-1:0]  addr_r;
   logic [data_width_p-1:0]  data_r;
   logic [strb_width_lp-1:0] strb_r;
   logic [data_width_p-1:0]  resp_data_r;
   logic                     err_r;
   logic                     awvalid_r, wvalid_r, bready_r;
   logic                     arvalid_r, rready_r, resp_v_r;

   logic [num_req_p-1:0]     grant;
   logic [id_width_lp-1:0]   grant_id;
   logic                     grant_v;
   logic                     grant_en;

   logic                     sel_w;
   logic [addr_width_p-1:0]  sel_addr;
   logic [data_width_p-1:0]  sel_data;
   logic [strb_width_lp-1:0] sel_strb;

   logic                     aw_done, w_done, owner_ready;

   // Gating with reset keeps yumi low while reset is held, even if requests are up.
   assign grant_en = (state_r == e_idle) && !reset_i;

   bsg_rr_grant #(.num_req_p(num_req_p)) rr_grant (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (grant_en),
      .req_i      (req_v_i),
      .grant_o    (grant),
      .grant_id_o (grant_id),
      .grant_v_o  (grant_v)
   );

   assign req_yumi_o = grant & {num_req_p{grant_en}};

   // One-hot grant selects the winner's command slice.
   always_comb begin
      sel_w    = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      sel_strb = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (grant[i]) begin
            sel_w    = req_w_i[i];
            sel_addr = req_addr_i[i*addr_width_p +: addr_width_p];
            sel_data = req_data_i[i*data_width_p +: data_width_p];
            sel_strb = req_mask_i[i*strb_width_lp +: strb_width_lp];
         end
      end
   end

   always_comb begin
      resp_v_o = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (owner_r == id_width_lp'(i)) resp_v_o[i] = resp_v_r;
      end
   end

   assign owner_ready = resp_ready_i[owner_r];

   // A channel counts as done once its valid is gone or handshakes this cycle.
   assign aw_done = !awvalid_r || m_axil_awready_i;
   assign w_done  = !wvalid_r  || m_axil_wready_i;

   // NOTE: the latched datapath is reset too, so the AXI address/data outputs
   // read as zero after reset instead of showing stale contents.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r     <= e_idle;
         owner_r     <= '0;
         addr_r      <= '0;
         data_r      <= '0;
         strb_r      <= '0;
         resp_data_r <= '0;
         err_r       <= 1'b0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         resp_v_r    <= 1'b0;
      end else begin
         unique case (state_r)
            e_idle: begin
               if (grant_v) begin
                  owner_r <= grant_id;
                  addr_r  <= sel_addr;
                  data_r  <= sel_data;
                  strb_r  <= sel_strb;
                  if (sel_w) begin
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= e_wr;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= e_rd;
                  end
               end
            end
            e_wr: begin
               if (m_axil_awready_i) awvalid_r <= 1'b0;
               if (m_axil_wready_i)  wvalid_r  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_r <= 1'b1;
                  state_r  <= e_wr_resp;
               end
            end
            e_wr_resp: begin
               if (m_axil_bvalid_i) begin
                  bready_r    <= 1'b0;
                  err_r       <= axi_resp_is_err(m_axil_bresp_i);
                  resp_data_r <= '0;
                  resp_v_r    <= 1'b1;
                  state_r     <= e_resp;
               end
            end
            e_rd: begin
               if (m_axil_arready_i) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= e_rd_resp;
               end
            end
            e_rd_resp: begin
               if (m_axil_rvalid_i) begin
                  rready_r    <= 1'b0;
                  err_r       <= axi_resp_is_err(m_axil_rresp_i);
                  resp_data_r <= m_axil_rdata_i;
                  resp_v_r    <= 1'b1;
                  state_r     <= e_resp;
               end
            end
            e_resp: begin
               if (owner_ready) begin
                  resp_v_r <= 1'b0;
                  state_r  <= e_idle;
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

   assign resp_data_o      = resp_data_r;
   assign resp_err_o       = err_r;

   assign m_axil_awaddr_o  = addr_r;
   assign m_axil_awprot_o  = axil_prot_c;
   assign m_axil_awvalid_o = awvalid_r;
   assign m_axil_wdata_o   = data_r;
   assign m_axil_wstrb_o   = strb_r;
   assign m_axil_wvalid_o  = wvalid_r;
   assign m_axil_bready_o  = bready_r;
   assign m_axil_araddr_o  = addr_r;
   assign m_axil_arprot_o  = axil_prot_c;
   assign m_axil_arvalid_o = arvalid_r;
   assign m_axil_rready_o  = rready_r;

endmodule

// File: tb/tb_bsg_axil_req_arbiter.sv
// Directed bench for bsg_axil_req_arbiter (2 requesters, 32-bit address/data).
// Inputs change 1-2 time units after the rising edge; outputs are sampled
// in the same low-activity window, well away from the next edge.
module tb_bsg_axil_req_arbiter;
   import bsg_axil_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_v, req_w, req_yumi, resp_v, resp_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N*SW-1:0] req_mask;
   logic [DW-1:0]   resp_data;
   logic            resp_err;
   logic [AW-1:0]   awaddr, araddr;
   logic [2:0]      awprot, arprot;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [DW-1:0]   wdata, rdata;
   logic [SW-1:0]   wstrb;
   logic [1:0]      bresp, rresp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bsg_axil_req_arbiter #(.num_req_p(N), .addr_width_p(AW), .data_width_p(DW)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .req_v_i          (req_v),
      .req_w_i          (req_w),
      .req_addr_i       (req_addr),
      .req_data_i       (req_data),
      .req_mask_i       (req_mask),
      .req_yumi_o       (req_yumi),
      .resp_v_o         (resp_v),
      .resp_data_o      (resp_data),
      .resp_err_o       (resp_err),
      .resp_ready_i     (resp_ready),
      .m_axil_awaddr_o  (awaddr),
      .m_axil_awprot_o  (awprot),
      .m_axil_awvalid_o (awvalid),
      .m_axil_awready_i (awready),
      .m_axil_wdata_o   (wdata),
      .m_axil_wstrb_o   (wstrb),
      .m_axil_wvalid_o  (wvalid),
      .m_axil_wready_i  (wready),
      .m_axil_bresp_i   (bresp),
      .m_axil_bvalid_i  (bvalid),
      .m_axil_bready_o  (bready),
      .m_axil_araddr_o  (araddr),
      .m_axil_arprot_o  (arprot),
      .m_axil_arvalid_o (arvalid),
      .m_axil_arready_i (arready),
      .m_axil_rdata_i   (rdata),
      .m_axil_rresp_i   (rresp),
      .m_axil_rvalid_i  (rvalid),
      .m_axil_rready_o  (rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait read for requester id; caller has req_v set and DUT idle.
   task automatic rd_txn(input int id, input logic [31:0] exp_addr,
                         input logic [31:0] d, input logic [1:0] r,
                         input logic exp_err, input string tag);
      logic [N-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      #1;
      chk({tag, "_yumi"}, req_yumi, oh);
      tick();
      chk({tag, "_arvalid"}, arvalid, 1'b1);
      chk({tag, "_araddr"}, araddr, exp_addr);
      chk({tag, "_busy_no_yumi"}, req_yumi, '0);
      tick();
      chk({tag, "_rready"}, rready, 1'b1);
      rvalid = 1'b1;
      rdata  = d;
      rresp  = r;
      tick();
      rvalid = 1'b0;
      chk({tag, "_resp_v"}, resp_v, oh);
      chk({tag, "_resp_data"}, resp_data, d);
      chk({tag, "_resp_err"}, resp_err, exp_err);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;   req_v = '0;  req_w = '0;   req_addr = '0; req_data = '0;
      req_mask = '0;  resp_ready = 2'b11;         awready = 1'b0; wready = 1'b0;
      bresp = '0;     bvalid = 1'b0; arready = 1'b0; rdata = '0;  rresp = '0;
      rvalid = 1'b0;

      // Reset state, including yumi held low while reset is asserted
      #2;
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_resp_v", resp_v, '0);
      chk("rst_resp_data", resp_data, '0);
      chk("rst_prot", {awprot, arprot}, '0);
      req_v = 2'b11;
      #1;
      chk("rst_yumi_gated", req_yumi, '0);
      req_v = '0;
      @(posedge clk); @(posedge clk); #3;
      reset = 1'b0;
      tick();

      // Test 1: single zero-wait read by requester 0
      arready = 1'b1;
      req_v = 2'b01; req_w = 2'b00; req_addr[31:0] = 32'h0000_1000;
      #1;
      chk("t1_yumi_c0", req_yumi, 2'b01);
      chk("t1_arvalid_c0", arvalid, 1'b0);
      tick();
      req_v = '0;
      chk("t1_arvalid_c1", arvalid, 1'b1);
      chk("t1_araddr", araddr, 32'h0000_1000);
      chk("t1_arprot", arprot, 3'b000);
      tick();
      chk("t1_rready_c2", rready, 1'b1);
      chk("t1_arvalid_c2", arvalid, 1'b0);
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = axi_resp_okay_c;
      tick();
      rvalid = 1'b0;
      chk("t1_resp_v_c3", resp_v, 2'b01);
      chk("t1_resp_data", resp_data, 32'hDEAD_BEEF);
      chk("t1_resp_err", resp_err, 1'b0);
      tick();
      chk("t1_resp_v_done", resp_v, '0);

      // Test 2: write by requester 1, W accepted 3 cycles before AW
      req_v = 2'b10; req_w = 2'b10;
      req_addr[63:32] = 32'h0000_2004; req_data[63:32] = 32'h0000_55AA; req_mask[7:4] = 4'b0011;
      #1;
      chk("t2_yumi", req_yumi, 2'b10);
      tick();
      req_v = '0;
      chk("t2_awvalid_a1", awvalid, 1'b1);
      chk("t2_wvalid_a1", wvalid, 1'b1);
      chk("t2_awaddr", awaddr, 32'h0000_2004);
      chk("t2_wdata", wdata, 32'h0000_55AA);
      chk("t2_wstrb", wstrb, 4'b0011);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      chk("t2_wvalid_dropped", wvalid, 1'b0);
      chk("t2_awvalid_a2", awvalid, 1'b1);
      tick();
      chk("t2_awvalid_a3", awvalid, 1'b1);
      chk("t2_bready_a3", bready, 1'b0);
      tick();
      chk("t2_awvalid_a4", awvalid, 1'b1);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("t2_awvalid_dropped", awvalid, 1'b0);
      chk("t2_bready", bready, 1'b1);
      chk("t2_resp_v_early", resp_v, '0);
      bvalid = 1'b1; bresp = axi_resp_okay_c;
      tick();
      bvalid = 1'b0;
      chk("t2_bready_once", bready, 1'b0);
      chk("t2_resp_v", resp_v, 2'b10);
      chk("t2_resp_data", resp_data, '0);
      chk("t2_resp_err", resp_err, 1'b0);
      tick();
      chk("t2_resp_v_done", resp_v, '0);

      // Test 3: contention, both requesters valid for four transactions
      req_w = 2'b00;
      req_addr = {32'h0000_B000, 32'h0000_A000};
      req_v = 2'b11;
      rd_txn(0, 32'h0000_A000, 32'h1111_1111, axi_resp_okay_c, 1'b0, "t3_g0");
      rd_txn(1, 32'h0000_B000, 32'h2222_2222, axi_resp_okay_c, 1'b0, "t3_g1");
      rd_txn(0, 32'h0000_A000, 32'h3333_3333, axi_resp_okay_c, 1'b0, "t3_g2");
      rd_txn(1, 32'h0000_B000, 32'h4444_4444, axi_resp_okay_c, 1'b0, "t3_g3");

      // Test 4: SLVERR read then OKAY read
      req_v = 2'b01;
      rd_txn(0, 32'h0000_A000, 32'hBAD0_0001, axi_resp_slverr_c, 1'b1, "t4_err");
      req_v = 2'b10;
      rd_txn(1, 32'h0000_B000, 32'h600D_0002, axi_resp_okay_c, 1'b0, "t4_ok");

      // Test 5: response backpressure on requester 0 while requester 1 waits
      req_v = 2'b01; resp_ready = 2'b10;
      #1;
      chk("t5_yumi", req_yumi, 2'b01);
      tick();
      req_v = 2'b10;
      #1;
      chk("t5_arvalid", arvalid, 1'b1);
      chk("t5_no_yumi_rd", req_yumi, '0);
      tick();
      rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = axi_resp_okay_c;
      tick();
      rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t5_resp_v_held", resp_v, 2'b01);
         chk("t5_resp_data_held", resp_data, 32'hCAFE_F00D);
         chk("t5_no_yumi", req_yumi, '0);
         tick();
      end
      resp_ready = 2'b11;
      #1;
      chk("t5_resp_v_last", resp_v, 2'b01);
      tick();
      rd_txn(1, 32'h0000_B000, 32'h5555_0005, axi_resp_okay_c, 1'b0, "t5_next");
      req_v = '0;

      // Test 6: asynchronous reset while waiting for B
      awready = 1'b1; wready = 1'b1;
      req_v = 2'b01; req_w = 2'b01;
      req_addr[31:0] = 32'h0000_3000; req_data[31:0] = 32'h1234_5678; req_mask[3:0] = 4'hF;
      #1;
      chk("t6_yumi", req_yumi, 2'b01);
      tick();
      req_v = '0;
      chk("t6_aw_w_valid", {awvalid, wvalid}, 2'b11);
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("t6_in_wr_resp", bready, 1'b1);
      req_v = 2'b11; req_w = 2'b00;
      #1;
      reset = 1'b1;
      #1;
      chk("t6_rst_bready", bready, 1'b0);
      chk("t6_rst_valids", {awvalid, wvalid, arvalid, rready}, '0);
      chk("t6_rst_resp_v", resp_v, '0);
      chk("t6_rst_resp_data", resp_data, '0);
      chk("t6_rst_resp_err", resp_err, 1'b0);
      chk("t6_rst_awaddr", awaddr, '0);
      chk("t6_rst_wdata", wdata, '0);
      chk("t6_rst_wstrb", wstrb, '0);
      chk("t6_rst_yumi", req_yumi, '0);
      #2;
      reset = 1'b0;
      rd_txn(0, 32'h0000_3000, 32'h7777_0007, axi_resp_okay_c, 1'b0, "t6_after");
      req_v = '0;
      tick();
      chk("t6_idle_resp_v", resp_v, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
